// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DROP = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_entry_t;

   localparam int          FIFO_DEPTH = 2;
   localparam logic [31:0] PC_STEP    = 32'd4;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry buffer of fetched {instr, pc} pairs; flush takes priority over push.
module fetch_fifo
   import fetch_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t wdata,
   output logic [1:0]   count,
   output fetch_entry_t head
);

   fetch_entry_t mem [FIFO_DEPTH];
   logic         rd_ptr;
   logic         wr_ptr;
   logic         pop_ok;

   assign pop_ok = pop & (count != 2'd0);
   assign head   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else if (flush) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop_ok) rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push} - {1'b0, pop_ok};
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Fetch PC, imem req/ack sequencing and redirect handling in front of decode.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc_plus8,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   output logic [1:0]  dbg_state
);

   fetch_state_t state, state_n;
   logic [31:0]  fetch_pc, fetch_pc_n;
   logic [31:0]  req_addr, req_addr_n;
   logic         ack, push, pop, flush;
   logic [1:0]   count, count_next;
   logic [31:0]  target;
   fetch_entry_t head;

   // State register; imem_req is its own flop so it never depends on inputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         fetch_pc <= word_align(RESET_PC);
         req_addr <= 32'd0;
         imem_req <= 1'b0;
      end else begin
         state    <= state_n;
         fetch_pc <= fetch_pc_n;
         req_addr <= req_addr_n;
         imem_req <= (state_n != S_IDLE);
      end
   end

   // A new request is issued only when its response is sure to find a slot.
   always_comb begin
      state_n    = state;
      fetch_pc_n = fetch_pc;
      req_addr_n = req_addr;
      if (br_taken) begin
         fetch_pc_n = target;
         if (state == S_IDLE || ack) begin
            state_n    = S_REQ;
            req_addr_n = target;
            fetch_pc_n = target + PC_STEP;
         end else begin
            state_n = S_DROP;
         end
      end else begin
         case (state)
            S_IDLE: begin
               if (count_next < 2'd2) begin
                  state_n    = S_REQ;
                  req_addr_n = fetch_pc;
                  fetch_pc_n = fetch_pc + PC_STEP;
               end
            end
            S_REQ: begin
               if (ack) begin
                  if (count_next < 2'd2) begin
                     req_addr_n = fetch_pc;
                     fetch_pc_n = fetch_pc + PC_STEP;
                  end else begin
                     state_n = S_IDLE;
                  end
               end
            end
            S_DROP: begin
               if (ack) begin
                  state_n    = S_REQ;
                  req_addr_n = fetch_pc;
                  fetch_pc_n = fetch_pc + PC_STEP;
               end
            end
            default: state_n = S_IDLE;
         endcase
      end
   end

   always_comb begin
      target     = word_align(br_target);
      ack        = imem_req & imem_ack;
      pop        = id_valid & id_ready;
      push       = (state == S_REQ) & ack & ~br_taken;
      flush      = br_taken;
      count_next = count + {1'b0, push} - {1'b0, pop};
   end

   fetch_fifo u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .wdata ({imem_rdata, req_addr}),
      .count (count),
      .head  (head)
   );

   assign imem_addr   = req_addr;
   assign id_valid    = (count != 2'd0);
   assign id_instr    = head.instr;
   assign id_pc       = head.pc;
   assign id_pc_plus8 = head.pc + 32'd8;
   assign dbg_state   = state;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and randomized checks of fetch_stage against a program-order model.
module tb_fetch_stage;

   logic        clk, reset;
   logic        imem_req, imem_ack, id_valid, id_ready, br_taken;
   logic [31:0] imem_addr, imem_rdata, id_instr, id_pc, id_pc_plus8, br_target;
   logic [1:0]  dbg_state;
   logic        w_req, w_valid, w_br_taken;
   logic [31:0] w_addr, w_rdata, w_instr, w_pc, w_pc_plus8, w_br_target;
   logic [1:0]  w_state;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_q[$];

   // Instruction memory content: a fixed scramble of the address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
   endfunction

   assign imem_rdata = mem_word(imem_addr);
   assign w_rdata    = mem_word(w_addr);

   fetch_stage dut (
      .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .id_valid(id_valid),
      .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
      .id_pc_plus8(id_pc_plus8), .br_taken(br_taken), .br_target(br_target),
      .dbg_state(dbg_state)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
      .clk(clk), .reset(reset), .imem_req(w_req), .imem_addr(w_addr),
      .imem_ack(imem_ack), .imem_rdata(w_rdata), .id_valid(w_valid),
      .id_ready(id_ready), .id_instr(w_instr), .id_pc(w_pc),
      .id_pc_plus8(w_pc_plus8), .br_taken(w_br_taken), .br_target(w_br_target),
      .dbg_state(w_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      reset = 1'b1; imem_ack = 1'b0; id_ready = 1'b0; br_taken = 1'b0; br_target = '0;
      w_br_taken = 1'b0; w_br_target = '0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %0b want 0", imem_req); end
      n_cmp++; if (imem_addr !== 32'd0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
      n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", id_valid); end
      n_cmp++; if (id_instr !== 32'd0) begin n_bad++; $display("FAIL reset_instr: got %h want 0", id_instr); end
      n_cmp++; if (id_pc !== 32'd0) begin n_bad++; $display("FAIL reset_pc: got %h want 0", id_pc); end
      n_cmp++; if (id_pc_plus8 !== 32'd8) begin n_bad++; $display("FAIL reset_pc8: got %h want 8", id_pc_plus8); end
      n_cmp++; if (w_req !== 1'b0) begin n_bad++; $display("FAIL reset_wrap_req: got %0b want 0", w_req); end
   endtask

   task automatic test_stream();
      logic [31:0] p;
      do_reset();
      imem_ack = 1'b1; id_ready = 1'b1; reset = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL stream_req k=%0d: got %0b want 1", k, imem_req); end
         n_cmp++; if (imem_addr !== 32'(4 * k)) begin n_bad++; $display("FAIL stream_addr k=%0d: got %h want %h", k, imem_addr, 32'(4 * k)); end
         if (k == 0) begin
            n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL stream_first_valid: got %0b want 0", id_valid); end
         end else begin
            p = 32'(4 * (k - 1));
            n_cmp++; if (id_valid !== 1'b1 || id_pc !== p) begin n_bad++; $display("FAIL stream_pc k=%0d: got v=%0b pc=%h want v=1 pc=%h", k, id_valid, id_pc, p); end
            n_cmp++; if (id_instr !== mem_word(p)) begin n_bad++; $display("FAIL stream_instr k=%0d: got %h want %h", k, id_instr, mem_word(p)); end
            n_cmp++; if (id_pc_plus8 !== p + 32'd8) begin n_bad++; $display("FAIL stream_pc8 k=%0d: got %h want %h", k, id_pc_plus8, p + 32'd8); end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] e;
      do_reset();
      imem_ack = 1'b1; id_ready = 1'b0; reset = 1'b0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL bp_req_low k=%0d: got %0b want 0", k, imem_req); end
         n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'd0) begin n_bad++; $display("FAIL bp_head k=%0d: got v=%0b pc=%h want v=1 pc=0", k, id_valid, id_pc); end
         if (k < 2) @(negedge clk);
      end
      id_ready = 1'b1;
      exp_q = {32'd0, 32'd4, 32'd8, 32'd12};
      for (int i = 0; i < 12 && exp_q.size() != 0; i++) begin
         if (i == 1) begin
            n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL bp_req_rise: got %0b want 1", imem_req); end
         end
         if (id_valid) begin
            e = exp_q.pop_front();
            n_cmp++; if (id_pc !== e || id_instr !== mem_word(e)) begin n_bad++; $display("FAIL bp_order: got pc=%h instr=%h want pc=%h instr=%h", id_pc, id_instr, e, mem_word(e)); end
         end
         @(negedge clk);
      end
      n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL bp_drain: got %0d left want 0", exp_q.size()); end
   endtask

   task automatic test_branch_wait();
      do_reset();
      imem_ack = 1'b1; id_ready = 1'b1; reset = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (imem_addr !== 32'd8) begin n_bad++; $display("FAIL bw_setup_addr: got %h want 8", imem_addr); end
      imem_ack = 1'b0; br_taken = 1'b1; br_target = 32'h100;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         br_taken = 1'b0;
         n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'd8) begin n_bad++; $display("FAIL bw_hold k=%0d: got req=%0b addr=%h want req=1 addr=8", k, imem_req, imem_addr); end
         n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL bw_valid k=%0d: got %0b want 0", k, id_valid); end
      end
      imem_ack = 1'b1;
      @(negedge clk);
      n_cmp++; if (imem_addr !== 32'h100 || id_valid !== 1'b0) begin n_bad++; $display("FAIL bw_target_req: got addr=%h v=%0b want addr=100 v=0", imem_addr, id_valid); end
      @(negedge clk);
      n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_instr !== mem_word(32'h100)) begin n_bad++; $display("FAIL bw_target_word: got v=%0b pc=%h instr=%h want v=1 pc=100", id_valid, id_pc, id_instr); end
   endtask

   task automatic test_branch_ack_pop();
      do_reset();
      imem_ack = 1'b1; id_ready = 1'b1; reset = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'd4) begin n_bad++; $display("FAIL bap_setup: got v=%0b pc=%h want v=1 pc=4", id_valid, id_pc); end
      br_taken = 1'b1; br_target = 32'h203;
      @(negedge clk);
      br_taken = 1'b0;
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin n_bad++; $display("FAIL bap_addr: got req=%0b addr=%h want req=1 addr=200", imem_req, imem_addr); end
      n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL bap_flush: got %0b want 0", id_valid); end
      @(negedge clk);
      n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h200) begin n_bad++; $display("FAIL bap_first: got v=%0b pc=%h want v=1 pc=200", id_valid, id_pc); end
      @(negedge clk);
      n_cmp++; if (id_pc !== 32'h204 || id_instr !== mem_word(32'h204)) begin n_bad++; $display("FAIL bap_second: got pc=%h instr=%h want pc=204", id_pc, id_instr); end
   endtask

   task automatic test_wrap();
      logic [31:0] a, p;
      do_reset();
      imem_ack = 1'b1; id_ready = 1'b1; reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         a = 32'hFFFF_FFF8 + 32'(4 * k);
         n_cmp++; if (w_addr !== a) begin n_bad++; $display("FAIL wrap_addr k=%0d: got %h want %h", k, w_addr, a); end
         if (k > 0) begin
            p = 32'hFFFF_FFF8 + 32'(4 * (k - 1));
            n_cmp++; if (w_pc !== p || w_pc_plus8 !== p + 32'd8 || w_instr !== mem_word(p)) begin n_bad++; $display("FAIL wrap_pc k=%0d: got pc=%h pc8=%h want pc=%h pc8=%h", k, w_pc, w_pc_plus8, p, p + 32'd8); end
         end
      end
   endtask

   task automatic test_reset_midreq();
      do_reset();
      imem_ack = 1'b0; id_ready = 1'b1; reset = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin n_bad++; $display("FAIL rm_wait: got req=%0b addr=%h want req=1 addr=0", imem_req, imem_addr); end
      reset = 1'b1; imem_ack = 1'b1;
      @(negedge clk);
      n_cmp++; if (imem_req !== 1'b0 || id_valid !== 1'b0) begin n_bad++; $display("FAIL rm_reset: got req=%0b v=%0b want 0 0", imem_req, id_valid); end
      reset = 1'b0;
      @(negedge clk);
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'd0 || id_valid !== 1'b0) begin n_bad++; $display("FAIL rm_restart: got req=%0b addr=%h v=%0b want 1 0 0", imem_req, imem_addr, id_valid); end
      @(negedge clk);
      n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'd0) begin n_bad++; $display("FAIL rm_first: got v=%0b pc=%h want v=1 pc=0", id_valid, id_pc); end
   endtask

   // Delivered words must follow program order: sequential +4, restarting at each target.
   task automatic test_random();
      logic [31:0] exp_pc, prev_addr, a;
      logic        prev_req, prev_ack, prev_br;
      int          stall;
      do_reset();
      reset = 1'b0;
      exp_pc = 32'd0; prev_req = 1'b0; prev_ack = 1'b0; prev_br = 1'b0; prev_addr = '0; stall = 0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         if (prev_br) begin
            n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL rnd_flush cyc=%0d: got %0b want 0", cyc, id_valid); end
         end
         if (prev_req && !prev_ack) begin
            n_cmp++; if (imem_addr !== prev_addr) begin n_bad++; $display("FAIL rnd_addr_stable cyc=%0d: got %h want %h", cyc, imem_addr, prev_addr); end
         end
         a = imem_addr;
         n_cmp++; if (a[1:0] !== 2'b00) begin n_bad++; $display("FAIL rnd_addr_align cyc=%0d: got %h", cyc, a); end
         imem_ack  = ($urandom_range(0, 99) < 60);
         id_ready  = ($urandom_range(0, 99) < 70);
         br_taken  = ($urandom_range(0, 99) < 4);
         br_target = $urandom;
         if (id_valid && id_ready) begin
            n_cmp++; if (id_pc !== exp_pc || id_instr !== mem_word(exp_pc) || id_pc_plus8 !== exp_pc + 32'd8) begin
               n_bad++; $display("FAIL rnd_pop cyc=%0d: got pc=%h instr=%h pc8=%h want pc=%h instr=%h", cyc, id_pc, id_instr, id_pc_plus8, exp_pc, mem_word(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
            stall = 0;
         end else if (id_ready) begin
            stall++;
         end
         if (br_taken) begin
            exp_pc = {br_target[31:2], 2'b00};
            stall = 0;
         end
         if (stall > 60) begin
            n_cmp++; n_bad++;
            $display("FAIL rnd_progress cyc=%0d: got no delivery for %0d ready cycles want <= 60", cyc, stall);
            break;
         end
         prev_req = imem_req; prev_ack = imem_ack; prev_addr = imem_addr; prev_br = br_taken;
         @(negedge clk);
      end
      br_taken = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_branch_wait();
      test_branch_ack_pop();
      test_wrap();
      test_reset_midreq();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
